rx_vc_buf: RTL and testbench

RX_VC_BUF -- requirements
Module: rx_vc_buf

---
 rtl/rx_vc_buf.sv | 136 +++++++++++++
 tb/tb_rx_vc_buf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_vc_buf.sv
// rx_vc_buf: per-VC receive flit FIFOs with packet framing checks and complete-packet accounting
package rx_vc_buf_pkg;
    localparam logic [1:0] HEAD_FLIT = 2'd0;
    localparam logic [1:0] BODY_FLIT = 2'd1;
    localparam logic [1:0] TAIL_FLIT = 2'd2;
endpackage

module rx_vc_buf
    import rx_vc_buf_pkg::*;
#(
    parameter int NumVirtChn = 2,
    parameter int FlitDataWidth = 32,
    parameter int BufDepth = 4,
    localparam int VcW = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1
) (
    input  logic                     clk_axi,
    input  logic                     arst_axi,
    input  logic                     in_valid,
    input  logic [FlitDataWidth-1:0] in_flit_data,
    input  logic [VcW-1:0]           in_vc,
    input  logic [1:0]               in_ftype,
    output logic                     in_ready,
    input  logic [VcW-1:0]           rd_vc,
    input  logic                     rd_en,
    output logic [FlitDataWidth-1:0] rd_data,
    output logic [1:0]               rd_ftype,
    output logic                     rd_valid,
    output logic [NumVirtChn-1:0]    vc_empty,
    output logic [NumVirtChn-1:0]    vc_full,
    output logic [NumVirtChn-1:0]    vc_pkt_avail,
    output logic [NumVirtChn-1:0]    vc_err,
    input  logic [NumVirtChn-1:0]    err_clr
);
    localparam int AW = $clog2(BufDepth);
    localparam int PtrW = AW + 1;
    localparam int CntW = $clog2(BufDepth + 1);
    localparam int EW = FlitDataWidth + 2;

    typedef enum logic {IDLE, IN_PKT} state_t;

    logic [EW-1:0]         mem [NumVirtChn][BufDepth];
    logic [PtrW-1:0]       wr_ptr [NumVirtChn];
    logic [PtrW-1:0]       rd_ptr [NumVirtChn];
    logic [CntW-1:0]       pkt_cnt [NumVirtChn];
    state_t                state_q [NumVirtChn];
    state_t                state_d [NumVirtChn];
    logic [NumVirtChn-1:0] wr_fire, rd_fire, pop_tail, err_set, cnt_inc;
    logic [EW-1:0]         rd_entry;

    // FIFO status and packet availability come straight from registered pointers and counters
    always_comb begin
        vc_empty = '0;
        vc_full = '0;
        vc_pkt_avail = '0;
        for (int i = 0; i < NumVirtChn; i++) begin
            vc_empty[i] = wr_ptr[i] == rd_ptr[i];
            vc_full[i] = (wr_ptr[i][AW] != rd_ptr[i][AW]) && (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            vc_pkt_avail[i] = pkt_cnt[i] != '0;
        end
    end

    // Input/read steering; an out-of-range VC matches no FIFO, so writes are dropped and in_ready stays 1
    always_comb begin
        in_ready = 1'b1;
        rd_valid = 1'b0;
        rd_entry = '0;
        wr_fire = '0;
        rd_fire = '0;
        pop_tail = '0;
        for (int i = 0; i < NumVirtChn; i++) begin
            if (in_vc == VcW'(i)) in_ready = !vc_full[i];
            if (rd_vc == VcW'(i)) begin
                rd_valid = !vc_empty[i];
                rd_entry = mem[i][rd_ptr[i][AW-1:0]];
            end
            wr_fire[i] = in_valid && (in_vc == VcW'(i)) && !vc_full[i];
            rd_fire[i] = rd_en && (rd_vc == VcW'(i)) && !vc_empty[i];
            pop_tail[i] = rd_fire[i] && (mem[i][rd_ptr[i][AW-1:0]][EW-1 -: 2] == TAIL_FLIT);
        end
    end

    assign rd_data = rd_entry[FlitDataWidth-1:0];
    assign rd_ftype = rd_entry[EW-1 -: 2];

    // Framing next-state: a HEAD opens a packet; flits outside a packet or a HEAD inside one are errors
    always_comb begin
        err_set = '0;
        cnt_inc = '0;
        for (int i = 0; i < NumVirtChn; i++) begin
            state_d[i] = state_q[i];
            if (wr_fire[i] && state_q[i] == IDLE) begin
                state_d[i] = (in_ftype == HEAD_FLIT) ? IN_PKT : IDLE;
                err_set[i] = in_ftype != HEAD_FLIT;
            end else if (wr_fire[i]) begin
                state_d[i] = (in_ftype == TAIL_FLIT) ? IDLE : IN_PKT;
                err_set[i] = in_ftype == HEAD_FLIT;
                cnt_inc[i] = in_ftype != BODY_FLIT;
            end
        end
    end

    // Framing state register
    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            for (int i = 0; i < NumVirtChn; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < NumVirtChn; i++) state_q[i] <= state_d[i];
        end
    end

    // Pointers, saturating packet counters and sticky errors (a new error beats err_clr)
    always_ff @(posedge clk_axi or negedge arst_axi) begin
        if (!arst_axi) begin
            for (int i = 0; i < NumVirtChn; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                pkt_cnt[i] <= '0;
            end
            vc_err <= '0;
        end else begin
            for (int i = 0; i < NumVirtChn; i++) begin
                if (wr_fire[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_fire[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (cnt_inc[i] && !pop_tail[i] && pkt_cnt[i] != CntW'(BufDepth)) pkt_cnt[i] <= pkt_cnt[i] + 1'b1;
                else if (pop_tail[i] && !cnt_inc[i] && pkt_cnt[i] != '0) pkt_cnt[i] <= pkt_cnt[i] - 1'b1;
            end
            vc_err <= err_set | (vc_err & ~err_clr);
        end
    end

    // Flit storage is not reset; contents are only observed while the FIFO is non-empty
    always_ff @(posedge clk_axi) begin
        for (int i = 0; i < NumVirtChn; i++)
            if (wr_fire[i]) mem[i][wr_ptr[i][AW-1:0]] <= {in_ftype, in_flit_data};
    end
endmodule

// File: tb/tb_rx_vc_buf.sv
// tb_rx_vc_buf: randomized and directed checks of rx_vc_buf against a queue-based reference model
module tb_rx_vc_buf;
    import rx_vc_buf_pkg::*;
    localparam int NVC = 2;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0]    t;
        logic [DW-1:0] d;
    } flit_t;

    logic           clk_axi = 1'b0;
    logic           arst_axi = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_flit_data = '0;
    logic           in_vc = 1'b0;
    logic [1:0]     in_ftype = '0;
    logic           in_ready;
    logic           rd_vc = 1'b0;
    logic           rd_en = 1'b0;
    logic [DW-1:0]  rd_data;
    logic [1:0]     rd_ftype;
    logic           rd_valid;
    logic [NVC-1:0] vc_empty, vc_full, vc_pkt_avail, vc_err;
    logic [NVC-1:0] err_clr = '0;

    int n_chk = 0;
    int n_pass = 0;

    flit_t    q [NVC][$];
    bit       in_pkt [NVC];
    int       cnt [NVC];
    bit [1:0] m_err;

    rx_vc_buf #(.NumVirtChn(NVC), .FlitDataWidth(DW), .BufDepth(DEPTH)) dut (
        .clk_axi(clk_axi), .arst_axi(arst_axi),
        .in_valid(in_valid), .in_flit_data(in_flit_data), .in_vc(in_vc), .in_ftype(in_ftype),
        .in_ready(in_ready),
        .rd_vc(rd_vc), .rd_en(rd_en), .rd_data(rd_data), .rd_ftype(rd_ftype), .rd_valid(rd_valid),
        .vc_empty(vc_empty), .vc_full(vc_full), .vc_pkt_avail(vc_pkt_avail), .vc_err(vc_err),
        .err_clr(err_clr)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic mreset();
        for (int v = 0; v < NVC; v++) begin
            q[v].delete();
            in_pkt[v] = 0;
            cnt[v] = 0;
        end
        m_err = '0;
    endtask

    task automatic check_model();
        logic [NVC-1:0] e_empty, e_full, e_avail;
        for (int v = 0; v < NVC; v++) begin
            e_empty[v] = q[v].size() == 0;
            e_full[v] = q[v].size() == DEPTH;
            e_avail[v] = cnt[v] > 0;
        end
        chk("vc_empty", vc_empty, e_empty);
        chk("vc_full", vc_full, e_full);
        chk("vc_pkt_avail", vc_pkt_avail, e_avail);
        chk("vc_err", vc_err, m_err);
        chk("in_ready", in_ready, q[in_vc].size() < DEPTH);
        chk("rd_valid", rd_valid, q[rd_vc].size() > 0);
        if (q[rd_vc].size() > 0) begin
            chk("rd_data", rd_data, q[rd_vc][0].d);
            chk("rd_ftype", rd_ftype, q[rd_vc][0].t);
        end
    endtask

    task automatic model_update();
        bit acc, pop;
        bit [1:0] set;
        int delta [NVC];
        acc = in_valid && q[in_vc].size() < DEPTH;
        pop = rd_en && q[rd_vc].size() > 0;
        set = '0;
        for (int v = 0; v < NVC; v++) delta[v] = 0;
        if (acc) begin
            if (!in_pkt[in_vc]) begin
                if (in_ftype == HEAD_FLIT) in_pkt[in_vc] = 1;
                else set[in_vc] = 1;
            end else if (in_ftype == TAIL_FLIT) begin
                in_pkt[in_vc] = 0;
                delta[in_vc]++;
            end else if (in_ftype == HEAD_FLIT) begin
                set[in_vc] = 1;
                delta[in_vc]++;
            end
        end
        if (pop && q[rd_vc][0].t == TAIL_FLIT) delta[rd_vc]--;
        for (int v = 0; v < NVC; v++) begin
            cnt[v] += delta[v];
            if (cnt[v] < 0) cnt[v] = 0;
            if (cnt[v] > DEPTH) cnt[v] = DEPTH;
        end
        m_err = set | (m_err & ~err_clr);
        if (pop) void'(q[rd_vc].pop_front());
        if (acc) q[in_vc].push_back({in_ftype, in_flit_data});
    endtask

    task automatic step();
        @(negedge clk_axi);
        check_model();
        model_update();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic ivc, input logic [1:0] ft, input logic [DW-1:0] d,
                       input logic re, input logic rvc, input logic [1:0] clr);
        in_valid = iv;
        in_vc = ivc;
        in_ftype = ft;
        in_flit_data = d;
        rd_en = re;
        rd_vc = rvc;
        err_clr = clr;
        step();
    endtask

    task automatic idle();
        in_valid = 0;
        rd_en = 0;
        err_clr = '0;
    endtask

    task automatic chk_reset(input string tag);
        in_vc = 0;
        rd_vc = 0;
        #1;
        chk({tag, "_empty"}, vc_empty, 2'b11);
        chk({tag, "_full"}, vc_full, 2'b00);
        chk({tag, "_avail"}, vc_pkt_avail, 2'b00);
        chk({tag, "_err"}, vc_err, 2'b00);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        idle();
        arst_axi = 0;
        mreset();
        chk_reset(tag);
        @(posedge clk_axi);
        @(negedge clk_axi);
        chk_reset({tag, "_hold"});
        arst_axi = 1;
        @(posedge clk_axi);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_d [3];
        logic [1:0]    exp_t [3];
        exp_d = '{32'hA, 32'hB, 32'hC};
        exp_t = '{HEAD_FLIT, BODY_FLIT, TAIL_FLIT};
        do_reset("por");

        // Framing: H,B,T on VC0 then three pops
        cyc(1, 0, HEAD_FLIT, 32'hA, 0, 0, 0);
        cyc(1, 0, BODY_FLIT, 32'hB, 0, 0, 0);
        cyc(1, 0, TAIL_FLIT, 32'hC, 0, 0, 0);
        idle();
        #1;
        chk("frame_avail_after_tail", vc_pkt_avail[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            idle();
            rd_vc = 0;
            #1;
            chk("frame_pop_data", rd_data, exp_d[k]);
            chk("frame_pop_type", rd_ftype, exp_t[k]);
            cyc(0, 0, BODY_FLIT, '0, 1, 0, 0);
        end
        idle();
        #1;
        chk("frame_avail_after_pops", vc_pkt_avail[0], 1'b0);

        // Full: four flits to VC1, no reads
        cyc(1, 1, HEAD_FLIT, 32'h10, 0, 0, 0);
        for (int k = 1; k < DEPTH; k++) cyc(1, 1, BODY_FLIT, 32'h10 + k, 0, 0, 0);
        idle();
        in_vc = 1;
        #1;
        chk("full_vc1", vc_full[1], 1'b1);
        chk("full_in_ready_vc1", in_ready, 1'b0);
        in_vc = 0;
        #1;
        chk("full_in_ready_vc0", in_ready, 1'b1);
        cyc(1, 1, BODY_FLIT, 32'hDEAD, 1, 1, 0);
        idle();
        in_vc = 1;
        #1;
        chk("full_in_ready_after_pop", in_ready, 1'b1);
        for (int k = 0; k < DEPTH - 1; k++) cyc(0, 0, BODY_FLIT, '0, 1, 1, 0);

        // Errors: BODY into idle VC0, clear, then error coinciding with clear
        cyc(1, 0, BODY_FLIT, 32'h55, 0, 0, 0);
        idle();
        rd_vc = 0;
        #1;
        chk("err_set", vc_err[0], 1'b1);
        chk("err_flit_stored", rd_data, 32'h55);
        cyc(0, 0, BODY_FLIT, '0, 0, 0, 2'b01);
        idle();
        #1;
        chk("err_cleared", vc_err[0], 1'b0);
        cyc(1, 0, BODY_FLIT, 32'h66, 0, 0, 2'b01);
        idle();
        #1;
        chk("err_set_beats_clr", vc_err[0], 1'b1);
        cyc(0, 0, BODY_FLIT, '0, 1, 0, 0);
        cyc(0, 0, BODY_FLIT, '0, 1, 0, 2'b01);

        // Concurrency: TAIL written while a TAIL is popped, pkt_cnt at 1
        cyc(1, 0, HEAD_FLIT, 32'h1, 0, 0, 0);
        cyc(1, 0, TAIL_FLIT, 32'h2, 0, 0, 0);
        cyc(1, 0, HEAD_FLIT, 32'h3, 0, 0, 0);
        cyc(0, 0, BODY_FLIT, '0, 1, 0, 0);
        cyc(1, 0, TAIL_FLIT, 32'h4, 1, 0, 0);
        idle();
        #1;
        chk("conc_avail_held", vc_pkt_avail[0], 1'b1);
        cyc(0, 0, BODY_FLIT, '0, 1, 0, 0);
        idle();
        #1;
        chk("conc_avail_after_head_pop", vc_pkt_avail[0], 1'b1);
        cyc(0, 0, BODY_FLIT, '0, 1, 0, 0);
        idle();
        #1;
        chk("conc_avail_after_tail_pop", vc_pkt_avail[0], 1'b0);

        // Wrap-around: interleaved write/read pairs on VC1 (still inside a packet)
        for (int k = 0; k < 10; k++) begin
            cyc(1, 1, BODY_FLIT, 32'h100 + k, 0, 1, 0);
            idle();
            rd_vc = 1;
            #1;
            chk("wrap_data", rd_data, 32'h100 + k);
            chk("wrap_not_full", vc_full[1], 1'b0);
            cyc(0, 1, BODY_FLIT, '0, 1, 1, 0);
            idle();
            #1;
            chk("wrap_empty", vc_empty[1], 1'b1);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom,
                $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);

        // Reset mid-packet with VC0 holding two flits
        do_reset("pre");
        cyc(1, 0, HEAD_FLIT, 32'h21, 0, 0, 0);
        cyc(1, 0, BODY_FLIT, 32'h22, 0, 0, 0);
        cyc(1, 1, BODY_FLIT, 32'h23, 0, 0, 0);
        do_reset("mid");
        cyc(1, 0, TAIL_FLIT, 32'h24, 0, 0, 0);
        idle();
        rd_vc = 0;
        #1;
        chk("post_reset_tail_err", vc_err[0], 1'b1);
        chk("post_reset_tail_avail", vc_pkt_avail[0], 1'b0);
        chk("post_reset_tail_data", rd_data, 32'h24);
        cyc(0, 0, BODY_FLIT, '0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
